// File: rtl/instruction_sequencer.sv
// Multi-cycle control sequencer: steps each instruction through FETCH/EXEC/MEM/STACK,
// gates single-cycle decoder writes, handles RAM handshake and stack faults, counts retirements.
module instruction_sequencer #(
    parameter int INSTR_WIDTH = 5,
    parameter int CNT_WIDTH   = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [INSTR_WIDTH-1:0] INSTRUCTION,
    input  logic                   MEM_READY,
    input  logic                   STACK_FULL,
    input  logic                   STACK_EMPTY,
    output logic                   IR_LOAD,
    output logic                   PC_INC,
    output logic                   PC_LOAD,
    output logic                   PC_SRC,
    output logic                   PC_CLR,
    output logic                   EXEC_EN,
    output logic                   ADDR_LATCH,
    output logic                   MEM_REQ,
    output logic                   MEM_WE,
    output logic                   ACC_LOAD_MEM,
    output logic                   STACK_PUSH,
    output logic                   STACK_POP,
    output logic                   STACK_SRC,
    output logic                   FAULT,
    output logic [2:0]             STATE,
    output logic [CNT_WIDTH-1:0]   RETIRED
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [INSTR_WIDTH-1:0] OP_JMP  = INSTR_WIDTH'(8'h0E);
    localparam logic [INSTR_WIDTH-1:0] OP_RST  = INSTR_WIDTH'(8'h0F);
    localparam logic [INSTR_WIDTH-1:0] OP_MOVL = INSTR_WIDTH'(8'h10);
    localparam logic [INSTR_WIDTH-1:0] OP_MOVS = INSTR_WIDTH'(8'h11);
    localparam logic [INSTR_WIDTH-1:0] OP_PUSH = INSTR_WIDTH'(8'h12);
    localparam logic [INSTR_WIDTH-1:0] OP_POP  = INSTR_WIDTH'(8'h13);
    localparam logic [INSTR_WIDTH-1:0] OP_CALL = INSTR_WIDTH'(8'h14);
    localparam logic [INSTR_WIDTH-1:0] OP_RET  = INSTR_WIDTH'(8'h15);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_STACK = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;
    logic [CNT_WIDTH-1:0]   retired_q;
    logic                   retire;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (retire) begin
                retired_q <= retired_q + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        retire       = 1'b0;
        IR_LOAD      = 1'b0;
        PC_INC       = 1'b0;
        PC_LOAD      = 1'b0;
        PC_SRC       = 1'b0;
        PC_CLR       = 1'b0;
        EXEC_EN      = 1'b0;
        ADDR_LATCH   = 1'b0;
        MEM_REQ      = 1'b0;
        MEM_WE       = 1'b0;
        ACC_LOAD_MEM = 1'b0;
        STACK_PUSH   = 1'b0;
        STACK_POP    = 1'b0;
        STACK_SRC    = 1'b0;
        FAULT        = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;

            S_FETCH: begin
                IR_LOAD = 1'b1;
                state_d = S_EXEC;
            end

            S_EXEC: begin
                case (INSTRUCTION)
                    OP_JMP: begin
                        PC_LOAD = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_RST: begin
                        PC_CLR  = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    OP_MOVL, OP_MOVS: begin
                        ADDR_LATCH = 1'b1;
                        wait_d     = '0;
                        state_d    = S_MEM;
                    end
                    OP_PUSH: begin
                        if (STACK_FULL) begin
                            state_d = S_FAULT;
                        end else begin
                            STACK_PUSH = 1'b1;
                            PC_INC     = 1'b1;
                            retire     = 1'b1;
                            state_d    = S_FETCH;
                        end
                    end
                    // POP and RET both need the registered stack top, valid one cycle later
                    OP_POP, OP_RET: begin
                        if (STACK_EMPTY) begin
                            state_d = S_FAULT;
                        end else begin
                            STACK_POP = 1'b1;
                            state_d   = S_STACK;
                        end
                    end
                    OP_CALL: begin
                        if (STACK_FULL) begin
                            state_d = S_FAULT;
                        end else begin
                            STACK_PUSH = 1'b1;
                            STACK_SRC  = 1'b1;
                            state_d    = S_STACK;
                        end
                    end
                    default: begin
                        EXEC_EN = 1'b1;
                        PC_INC  = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end

            S_MEM: begin
                MEM_REQ = 1'b1;
                MEM_WE  = (INSTRUCTION == OP_MOVS);
                if (MEM_READY) begin
                    ACC_LOAD_MEM = (INSTRUCTION == OP_MOVL);
                    PC_INC       = 1'b1;
                    retire       = 1'b1;
                    state_d      = S_FETCH;
                end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            S_STACK: begin
                case (INSTRUCTION)
                    OP_POP: begin
                        EXEC_EN = 1'b1;
                        PC_INC  = 1'b1;
                    end
                    OP_CALL: PC_LOAD = 1'b1;
                    OP_RET: begin
                        PC_LOAD = 1'b1;
                        PC_SRC  = 1'b1;
                    end
                    default: ;
                endcase
                retire  = 1'b1;
                state_d = S_FETCH;
            end

            S_FAULT: FAULT = 1'b1;

            default: state_d = S_FETCH;
        endcase
    end

    assign STATE   = state_q;
    assign RETIRED = retired_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer: a per-instruction cycle model builds the expected
// output trace, one negedge process compares it, and literal checks pin key counts.
module tb_instruction_sequencer;

    localparam int TO = 15;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [4:0]  INSTRUCTION = 5'h00;
    logic        MEM_READY = 1'b0, STACK_FULL = 1'b0, STACK_EMPTY = 1'b0;
    logic        IR_LOAD, PC_INC, PC_LOAD, PC_SRC, PC_CLR, EXEC_EN, ADDR_LATCH;
    logic        MEM_REQ, MEM_WE, ACC_LOAD_MEM, STACK_PUSH, STACK_POP, STACK_SRC, FAULT;
    logic [2:0]  STATE;
    logic [15:0] RETIRED;

    instruction_sequencer #(.INSTR_WIDTH(5), .CNT_WIDTH(16), .MEM_TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST), .INSTRUCTION(INSTRUCTION), .MEM_READY(MEM_READY),
        .STACK_FULL(STACK_FULL), .STACK_EMPTY(STACK_EMPTY),
        .IR_LOAD(IR_LOAD), .PC_INC(PC_INC), .PC_LOAD(PC_LOAD), .PC_SRC(PC_SRC),
        .PC_CLR(PC_CLR), .EXEC_EN(EXEC_EN), .ADDR_LATCH(ADDR_LATCH), .MEM_REQ(MEM_REQ),
        .MEM_WE(MEM_WE), .ACC_LOAD_MEM(ACC_LOAD_MEM), .STACK_PUSH(STACK_PUSH),
        .STACK_POP(STACK_POP), .STACK_SRC(STACK_SRC), .FAULT(FAULT), .STATE(STATE),
        .RETIRED(RETIRED)
    );

    always #5 CLK = ~CLK;

    localparam logic [13:0] B_IR    = 14'h2000, B_PCINC = 14'h1000, B_PCLD  = 14'h0800;
    localparam logic [13:0] B_PCSRC = 14'h0400, B_PCCLR = 14'h0200, B_EXEC  = 14'h0100;
    localparam logic [13:0] B_ADDR  = 14'h0080, B_MREQ  = 14'h0040, B_MWE   = 14'h0020;
    localparam logic [13:0] B_ACC   = 14'h0010, B_PUSH  = 14'h0008, B_POP   = 14'h0004;
    localparam logic [13:0] B_SSRC  = 14'h0002, B_FLT   = 14'h0001;

    typedef struct packed {
        logic [13:0] s;
        logic [2:0]  st;
        logic [15:0] ret;
    } exp_t;

    exp_t        expq[$];
    int          n_cmp = 0, n_bad = 0, mreq_cnt = 0;
    logic [15:0] m_ret = 16'd0;
    bit          m_fault = 1'b0;

    function automatic logic [13:0] strobes();
        return {IR_LOAD, PC_INC, PC_LOAD, PC_SRC, PC_CLR, EXEC_EN, ADDR_LATCH,
                MEM_REQ, MEM_WE, ACC_LOAD_MEM, STACK_PUSH, STACK_POP, STACK_SRC, FAULT};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] st, input logic [13:0] s);
        exp_t r;
        r.s   = s;
        r.st  = st;
        r.ret = m_ret;
        return r;
    endfunction

    always @(negedge CLK) begin
        exp_t e;
        if (expq.size() != 0) begin
            e = expq.pop_front();
            chk("strobes", 32'(strobes()), 32'(e.s));
            chk("state", 32'(STATE), 32'(e.st));
            chk("retired", 32'(RETIRED), 32'(e.ret));
        end
        if (MEM_REQ) mreq_cnt++;
    end

    task automatic step(input logic [4:0] op, input logic rdy, input logic full, input logic empty,
                        input logic [2:0] st, input logic [13:0] s);
        @(posedge CLK);
        #1;
        INSTRUCTION = op;
        MEM_READY   = rdy;
        STACK_FULL  = full;
        STACK_EMPTY = empty;
        expq.push_back(mk(st, s));
    endtask

    task automatic fetch(input logic [4:0] op, input logic f, input logic e);
        step(op, 1'b0, f, e, 3'd1, B_IR);
    endtask

    // Expected cycles after FETCH, derived from each opcode's documented behaviour
    task automatic body(input logic [4:0] op, input int delay, input logic f, input logic e);
        logic [13:0] s;
        logic        rdy;
        int          k;
        bit          done;
        case (op)
            5'h10, 5'h11: begin
                step(op, 1'b0, f, e, 3'd2, B_ADDR);
                k = 0;
                done = 1'b0;
                while (!done) begin
                    rdy = (delay >= 0) && (k == delay);
                    s = B_MREQ | ((op == 5'h11) ? B_MWE : 14'h0);
                    if (rdy) s = s | B_PCINC | ((op == 5'h10) ? B_ACC : 14'h0);
                    step(op, rdy, f, e, 3'd3, s);
                    if (rdy) begin
                        m_ret++;
                        done = 1'b1;
                    end else begin
                        k++;
                        if (k == TO) begin
                            m_fault = 1'b1;
                            done = 1'b1;
                        end
                    end
                end
            end
            5'h0E: begin step(op, 1'b0, f, e, 3'd2, B_PCLD); m_ret++; end
            5'h0F: begin step(op, 1'b0, f, e, 3'd2, B_PCCLR); m_ret++; end
            5'h12: begin
                if (f) begin step(op, 1'b0, f, e, 3'd2, 14'h0); m_fault = 1'b1; end
                else begin step(op, 1'b0, f, e, 3'd2, B_PUSH | B_PCINC); m_ret++; end
            end
            5'h13: begin
                if (e) begin step(op, 1'b0, f, e, 3'd2, 14'h0); m_fault = 1'b1; end
                else begin
                    step(op, 1'b0, f, e, 3'd2, B_POP);
                    step(op, 1'b0, f, e, 3'd4, B_EXEC | B_PCINC);
                    m_ret++;
                end
            end
            5'h14: begin
                if (f) begin step(op, 1'b0, f, e, 3'd2, 14'h0); m_fault = 1'b1; end
                else begin
                    step(op, 1'b0, f, e, 3'd2, B_PUSH | B_SSRC);
                    step(op, 1'b0, f, e, 3'd4, B_PCLD);
                    m_ret++;
                end
            end
            5'h15: begin
                if (e) begin step(op, 1'b0, f, e, 3'd2, 14'h0); m_fault = 1'b1; end
                else begin
                    step(op, 1'b0, f, e, 3'd2, B_POP);
                    step(op, 1'b0, f, e, 3'd4, B_PCLD | B_PCSRC);
                    m_ret++;
                end
            end
            default: begin step(op, 1'b0, f, e, 3'd2, B_EXEC | B_PCINC); m_ret++; end
        endcase
    endtask

    task automatic run(input logic [4:0] op, input int delay, input logic f, input logic e);
        fetch(op, f, e);
        body(op, delay, f, e);
    endtask

    task automatic fault_steps(input int n);
        for (int i = 0; i < n; i++)
            step(INSTRUCTION, MEM_READY, STACK_FULL, STACK_EMPTY, 3'd5, B_FLT);
    endtask

    task automatic rst_assert();
        RST = 1'b1;
        #1;
        chk("rst_state", 32'(STATE), 32'd0);
        chk("rst_strobes", 32'(strobes()), 32'd0);
        chk("rst_retired", 32'(RETIRED), 32'd0);
        m_ret = 16'd0;
        m_fault = 1'b0;
    endtask

    task automatic rst_release();
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        INSTRUCTION = 5'h00;
        MEM_READY = 1'b0;
        STACK_FULL = 1'b0;
        STACK_EMPTY = 1'b0;
        expq.push_back(mk(3'd0, 14'h0));
    endtask

    task automatic do_reset();
        @(negedge CLK);
        #1;
        rst_assert();
        rst_release();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int c0;
        do_reset();
        run(5'h05, 0, 1'b0, 1'b0);
        run(5'h09, 0, 1'b0, 1'b0);
        fetch(5'h10, 1'b0, 1'b0);
        chk("retired_after_two_ops", 32'(RETIRED), 32'd2);
        c0 = mreq_cnt;
        body(5'h10, 3, 1'b0, 1'b0);
        @(negedge CLK); #1;
        chk("movld_mreq_cycles", 32'(mreq_cnt - c0), 32'd4);
        run(5'h11, 0, 1'b0, 1'b0);
        run(5'h0E, 0, 1'b0, 1'b0);
        run(5'h0F, 0, 1'b0, 1'b0);
        run(5'h12, 0, 1'b0, 1'b0);
        run(5'h13, 0, 1'b0, 1'b0);
        run(5'h1F, 0, 1'b0, 1'b0);
        run(5'h14, 0, 1'b0, 1'b0);
        run(5'h15, 0, 1'b0, 1'b0);
        fetch(5'h11, 1'b0, 1'b0);
        chk("retired_after_eleven_ops", 32'(RETIRED), 32'd11);
        c0 = mreq_cnt;
        body(5'h11, -1, 1'b0, 1'b0);
        fault_steps(3);
        @(negedge CLK); #1;
        chk("timeout_mreq_cycles", 32'(mreq_cnt - c0), 32'd15);
        chk("timeout_fault", 32'(FAULT), 32'd1);
        chk("timeout_retired", 32'(RETIRED), 32'd11);

        do_reset();
        run(5'h12, 0, 1'b1, 1'b0);
        fault_steps(2);
        @(negedge CLK); #1;
        chk("push_full_retired", 32'(RETIRED), 32'd0);
        do_reset();
        run(5'h13, 0, 1'b0, 1'b1);
        fault_steps(1);
        do_reset();
        run(5'h14, 0, 1'b1, 1'b1);
        fault_steps(1);
        do_reset();
        run(5'h15, 0, 1'b1, 1'b1);
        fault_steps(1);

        do_reset();
        run(5'h05, 0, 1'b0, 1'b0);
        fetch(5'h10, 1'b0, 1'b0);
        step(5'h10, 1'b0, 1'b0, 1'b0, 3'd2, B_ADDR);
        step(5'h10, 1'b0, 1'b0, 1'b0, 3'd3, B_MREQ);
        step(5'h10, 1'b0, 1'b0, 1'b0, 3'd3, B_MREQ);
        @(negedge CLK); #1;
        rst_assert();
        chk("midmem_mem_req", 32'(MEM_REQ), 32'd0);
        rst_release();
        run(5'h05, 0, 1'b0, 1'b0);
        @(negedge CLK); #2;
        chk("queue_drained", 32'(expq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
- Multi-cycle control sequencer between the instruction register, `instruction_decoder` and the datapath (PC, RAM, stack, ACC).
- Splits each instruction into FETCH / EXEC / MEM / STACK phases so that two-cycle opcodes work: MOV A,#addr, MOV #addr,A, CALL and RET.
- Gates the decoder's single-cycle enables with `EXEC_EN`.
- Handles the RAM ready handshake and stack overflow/underflow faults, and counts retired instructions.

Parameters:
- INSTR_WIDTH, 5, opcode width; must match `instruction_decoder`.
- CNT_WIDTH, 16, width of the retired-instruction counter.
- MEM_TIMEOUT, 15, maximum wait cycles for MEM_READY before a fault; value must be ≥1.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RST  input  1  asynchronous, active-high reset.
- INSTRUCTION  input  INSTR_WIDTH  opcode from the instruction register; stable from the cycle after IR_LOAD.
- MEM_READY  input  1  RAM handshake: read data valid / write accepted this cycle.
- STACK_FULL  input  1  stack cannot accept a push.
- STACK_EMPTY  input  1  stack holds no entries.
- IR_LOAD  output  1  instruction register captures the word at PC.
- PC_INC  output  1  PC <= PC+1.
- PC_LOAD  output  1  PC loads the target selected by PC_SRC.
- PC_SRC  output  1  0 = immediate field, 1 = stack top.
- PC_CLR  output  1  PC <= 0.
- EXEC_EN  output  1  permits the decoder's CE_ACC/REG_WR writes this cycle.
- ADDR_LATCH  output  1  RAM address register captures the immediate.
- MEM_REQ  output  1  RAM access in progress.
- MEM_WE  output  1  with MEM_REQ: write ACC to RAM.
- ACC_LOAD_MEM  output  1  ACC captures RAM read data.
- STACK_PUSH  output  1  push one entry.
- STACK_POP  output  1  pop one entry; stack top is registered, so it is valid the next cycle.
- STACK_SRC  output  1  push source: 0 = ACC, 1 = PC+1.
- FAULT  output  1  sticky error flag.
- STATE  output  3  current state, for debug.
- RETIRED  output  CNT_WIDTH  count of completed instructions.

Behaviour:
- State encoding: IDLE=0, FETCH=1, EXEC=2, MEM=3, STACK=4, FAULT_ST=5; codes 6 and 7 recover to FETCH.
- Outputs are combinational from the registered state and INSTRUCTION. Any strobe not listed for a state is 0.
- Reset:
  - During and at release: state IDLE, all strobes 0, FAULT=0, RETIRED=0, wait counter 0.
  - IDLE -> FETCH unconditionally on the next edge.
  - Reset asserted in any state, including mid-MEM, aborts immediately. MEM_REQ drops asynchronously and no partial write strobe may follow.
- FETCH: IR_LOAD=1 -> EXEC.
- EXEC, by opcode:
  - 0x00-0x0D and 0x16-0x1F (single-cycle ALU/LD/ST/NOP/LDI): EXEC_EN=1, PC_INC=1, retire, -> FETCH.
  - 0x0E JMP: PC_LOAD=1, PC_SRC=0, retire, -> FETCH.
  - 0x0F RST: PC_CLR=1, retire, -> FETCH. RETIRED is not cleared.
  - 0x10 and 0x11 MOV: ADDR_LATCH=1, clear wait counter, -> MEM.
  - 0x12 PUSH:
    - If STACK_FULL: -> FAULT_ST, no push.
    - Else: STACK_PUSH=1, STACK_SRC=0, PC_INC=1, retire, -> FETCH.
  - 0x13 POP:
    - If STACK_EMPTY: -> FAULT_ST.
    - Else: STACK_POP=1 -> STACK.
  - 0x14 CALL:
    - If STACK_FULL: -> FAULT_ST.
    - Else: STACK_PUSH=1, STACK_SRC=1 -> STACK.
  - 0x15 RET:
    - If STACK_EMPTY: -> FAULT_ST.
    - Else: STACK_POP=1 -> STACK.
- MEM:
  - MEM_REQ=1. MEM_WE=1 for 0x11, 0 for 0x10. Held constant until MEM_READY.
  - MEM_READY=1: for 0x10 ACC_LOAD_MEM=1; PC_INC=1, retire, -> FETCH. MEM_READY in the first MEM cycle is legal (two-cycle op).
  - MEM_READY=0: wait counter +1. When the counter reaches MEM_TIMEOUT with no ready, -> FAULT_ST, no PC change.
- STACK:
  - POP: EXEC_EN=1 (ACC written from stack top), PC_INC=1.
  - CALL: PC_LOAD=1, PC_SRC=0.
  - RET: PC_LOAD=1, PC_SRC=1.
  - All three retire and -> FETCH.
- FAULT_ST: all strobes 0, FAULT=1. Remains until RST; there is no other exit.
- RETIRED:
  - +1 on each retire edge, i.e. exactly one pulse per completed instruction.
  - Wraps modulo 2^CNT_WIDTH, no saturation.
  - Never increments on faulting instructions.
- Latency: 2 cycles for single-cycle ops, JMP, RST and PUSH. 3 cycles for POP/CALL/RET. 3+N cycles for MOV with N wait cycles.
- Simultaneous inputs: STACK_FULL and STACK_EMPTY both 1 is treated as given: PUSH/CALL fault, POP/RET fault.

Test Plan:
- Reset release, then opcodes 0x05, 0x09 -> IR_LOAD at cycles 1 and 3; EXEC_EN+PC_INC at cycles 2 and 4; RETIRED=2; no MEM_REQ or stack strobes.
- 0x10 with MEM_READY delayed 3 cycles -> ADDR_LATCH for 1 cycle; then MEM_REQ=1 with MEM_WE=0 for 4 cycles; ACC_LOAD_MEM+PC_INC in the 4th cycle only; total 6 cycles.
- 0x11 with MEM_READY immediate -> MEM_WE=1 for exactly 1 cycle; then FETCH.
- 0x11 with MEM_READY never asserted -> exactly MEM_TIMEOUT=15 cycles of MEM_REQ, then FAULT=1 and all strobes 0.
- 0x14 CALL then 0x15 RET:
  - CALL: STACK_PUSH with STACK_SRC=1, next cycle PC_LOAD with PC_SRC=0.
  - RET: STACK_POP, next cycle PC_LOAD with PC_SRC=1.
  - RETIRED +2.
- 0x12 with STACK_FULL=1 -> FAULT within 1 cycle, no STACK_PUSH, RETIRED unchanged.
- RST asserted mid-MEM -> FAULT=0, RETIRED=0, STATE=IDLE, then FETCH on the 1st edge after release.
